// File: rtl/mem_dump_reader.sv
// mem_dump_reader: after a halt, walks data memory from address 0 and
// streams every word, LSB byte first, to the debug UART transmitter.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   start             - dump request, sampled only while idle
//   mem_rd, mem_addr  - memory read port (data returns one cycle later)
//   mem_data          - memory read data
//   tx_data, tx_valid - byte to the UART transmitter (registered)
//   tx_ready          - transmitter accepts on tx_valid & tx_ready
//   busy              - high whenever not idle
//   done              - one-cycle pulse when the dump has completed
//
// Optional build macro DUMP_CHECKSUM_EN: appends one XOR checksum byte
// covering every data byte sent, transmitted just before completion.
module mem_dump_reader #(
    parameter int len_data   = 32,
    parameter int addr_bits  = 11,
    parameter int dump_words = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 mem_rd,
    output logic [addr_bits-1:0] mem_addr,
    input  logic [len_data-1:0]  mem_data,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int NBYTES = len_data / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [addr_bits-1:0] LAST_WORD = addr_bits'(dump_words - 1);
    localparam logic [BCW-1:0]       LAST_BYTE = BCW'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_NEXT,
`ifdef DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [addr_bits-1:0]  word_q, word_d;
    logic [BCW-1:0]        byte_q, byte_d;
    logic [len_data-1:0]   shift_q, shift_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [addr_bits-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    // Outputs are computed from the next state so they appear as flops.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        byte_d     = byte_q;
        shift_d    = shift_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_READ;
                    word_d     = '0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = '0;
`ifdef DUMP_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                shift_d    = mem_data;
                byte_d     = '0;
                tx_data_d  = mem_data[7:0];
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    shift_d = shift_q >> 8;
                    byte_d  = byte_q + BCW'(1);
`ifdef DUMP_CHECKSUM_EN
                    csum_d  = csum_q ^ tx_data_q;
`endif
                    if (byte_q == LAST_BYTE) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_NEXT;
                    end else begin
                        tx_data_d = shift_d[7:0];
                    end
                end
            end
            S_NEXT: begin
                if (word_q == LAST_WORD) begin
`ifdef DUMP_CHECKSUM_EN
                    tx_data_d  = csum_q;
                    tx_valid_d = 1'b1;
                    state_d    = S_CSUM;
`else
                    done_d  = 1'b1;
                    state_d = S_DONE;
`endif
                end else begin
                    word_d     = word_q + addr_bits'(1);
                    mem_rd_d   = 1'b1;
                    mem_addr_d = word_q + addr_bits'(1);
                    state_d    = S_READ;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: scoreboard bench for mem_dump_reader with a
// 4-word memory model, random data and randomised transmitter stalls.
module tb_mem_dump_reader;

    localparam int DW = 4;
    localparam int AB = 2;
`ifdef DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int LAT = 7 * DW + CS;

    logic          clk;
    logic          reset;
    logic          start;
    logic          mem_rd;
    logic [AB-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;

    mem_dump_reader #(
        .len_data   (32),
        .addr_bits  (AB),
        .dump_words (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [DW];
    logic [7:0]  exp_q[$];
    int          exp_addr[$];
    logic [7:0]  got[$];
    int          n_acc = 0;
    int          rdy_mode = 0;
    logic [7:0]  last_cs;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle registered-read memory.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    // Transmitter ready: 0 = always, 1 = random, 2 = five-cycle stall per byte.
    initial begin
        int stall;
        stall = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                tx_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                tx_ready = 1'($urandom_range(0, 1));
            end else if (tx_ready) begin
                tx_ready = 1'b0;
                stall = 0;
            end else if (tx_valid) begin
                stall++;
                if (stall >= 5) tx_ready = 1'b1;
            end
        end
    end

    // Monitor: compares reads and accepted bytes against the scoreboard.
    initial begin
        bit         pv, pr, prd;
        logic [7:0] pd, eb;
        int         ea;
        pv = 0; pr = 0; prd = 0; pd = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 0; pr = 0; prd = 0;
            end else begin
                if (mem_rd) begin
                    checks++;
                    if (exp_addr.size() == 0) begin
                        errors++;
                        $display("FAIL rd_unexpected addr=%0d", mem_addr);
                    end else begin
                        ea = exp_addr.pop_front();
                        if (mem_addr !== AB'(ea)) begin
                            errors++;
                            $display("FAIL rd_addr got=%0d exp=%0d", mem_addr, ea);
                        end
                    end
                    checks++;
                    if (prd) begin
                        errors++;
                        $display("FAIL rd_pulse got=two-cycle exp=one-cycle");
                    end
                end
                if (pv && !pr) begin
                    checks++;
                    if (tx_valid !== 1'b1 || tx_data !== pd) begin
                        errors++;
                        $display("FAIL hold got=%b/%h exp=1/%h", tx_valid, tx_data, pd);
                    end
                end
                if (tx_valid && tx_ready) begin
                    checks++;
                    got.push_back(tx_data);
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL byte_extra got=%h exp=none", tx_data);
                    end else begin
                        eb = exp_q.pop_front();
                        if (tx_data !== eb) begin
                            errors++;
                            $display("FAIL byte got=%h exp=%h", tx_data, eb);
                        end
                    end
                end
                if (done) begin
                    checks++;
                    if (exp_q.size() != 0 || exp_addr.size() != 0) begin
                        errors++;
                        $display("FAIL done_early got=%0d/%0d left exp=0/0",
                                 exp_q.size(), exp_addr.size());
                    end
                end
                pv = tx_valid; pr = tx_ready; pd = tx_data; prd = mem_rd;
            end
        end
    end

    // Reference model: every word in address order, LSB byte first,
    // optionally followed by the XOR of all data bytes.
    task automatic push_expected();
        logic [7:0] b;
        logic [7:0] cs;
        cs = '0;
        got.delete();
        n_acc = 0;
        for (int w = 0; w < DW; w++) begin
            exp_addr.push_back(w);
            for (int k = 0; k < 4; k++) begin
                b = 8'(mem[w] >> (8 * k));
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
        last_cs = cs;
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic set_mode(input int m);
        rdy_mode = m;
        tx_ready = (m == 0);
    endtask

    // Called #1 after the edge that sampled start.
    task automatic run_body(input int lat, input bit mid);
        int cyc;
        cyc = 0;
        checks++;
        if (mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL first_rd got=%b exp=1", mem_rd);
        end
        start = 1'b0;
        while (done !== 1'b1 && cyc < 3000) begin
            start = mid && (cyc == 9);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout got=%0d cycles exp=done", cyc);
        end else begin
            if (lat >= 0) begin
                checks++;
                if (cyc != lat) begin
                    errors++;
                    $display("FAIL latency got=%0d exp=%0d", cyc, lat);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_at_done got=%b exp=1", busy);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse got=%b/%b exp=0/0", done, busy);
            end
            repeat (3) begin
                @(posedge clk);
                #1;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_stay got=%b exp=0", busy);
                end
            end
        end
        checks++;
        if (got.size() != DW * 4 + CS) begin
            errors++;
            $display("FAIL byte_count got=%0d exp=%0d", got.size(), DW * 4 + CS);
        end
    endtask

    task automatic kick();
        push_expected();
        start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_byte(input int idx, input logic [7:0] e);
        checks++;
        if (got.size() <= idx) begin
            errors++;
            $display("FAIL byte_%0d got=missing exp=%h", idx, e);
        end else if (got[idx] !== e) begin
            errors++;
            $display("FAIL byte_%0d got=%h exp=%h", idx, got[idx], e);
        end
    endtask

    initial begin
        int cyc;
        mem_data = '0;
        tx_ready = 1'b1;
        reset    = 1'b1;
        start    = 1'b1;
        for (int i = 0; i < DW; i++) mem[i] = 32'(i + 1);

        // Reset held with start high: everything stays cleared.
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if ({mem_rd, mem_addr, tx_data, tx_valid, busy, done} !== '0) begin
                errors++;
                $display("FAIL reset_outs got=%b%b%h%b%b%b exp=0",
                         mem_rd, mem_addr, tx_data, tx_valid, busy, done);
            end
        end

        // Multi-word dump straight out of reset, with a stray start mid-dump.
        set_mode(0);
        push_expected();
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_body(LAT, 1'b1);
        check_byte(4, 8'h02);
        check_byte(12, 8'h04);

        // Single word pattern, byte order.
        mem[0] = 32'h11223344;
        set_mode(0);
        kick();
        run_body(LAT, 1'b0);
        check_byte(0, 8'h44);
        check_byte(1, 8'h33);
        check_byte(2, 8'h22);
        check_byte(3, 8'h11);

        // Backpressure on every byte.
        mem[0] = 32'hDEADBEEF;
        set_mode(2);
        kick();
        run_body(-1, 1'b0);
        check_byte(0, 8'hEF);
        check_byte(1, 8'hBE);

        // Checksum pattern.
        mem[0] = 32'h000000FF;
        mem[1] = 32'h01000000;
        mem[2] = 32'h0;
        mem[3] = 32'h0;
        set_mode(0);
        kick();
        run_body(LAT, 1'b0);
`ifdef DUMP_CHECKSUM_EN
        check_byte(16, 8'hFE);
`endif

        // Random data with random stalls.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < DW; i++) mem[i] = $urandom;
            set_mode(1);
            kick();
            run_body(-1, 1'($urandom_range(0, 1)));
        end

        // Reset during the second byte of word 1, then a clean restart.
        for (int i = 0; i < DW; i++) mem[i] = $urandom;
        set_mode(0);
        kick();
        start = 1'b0;
        cyc = 0;
        while (!(n_acc >= 5 && tx_valid === 1'b1) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (n_acc != 5) begin
            errors++;
            $display("FAIL mid_reach got=%0d exp=5", n_acc);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got=%b/%b/%b exp=0/0/0", tx_valid, busy, mem_rd);
        end
        exp_q.delete();
        exp_addr.delete();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < DW; i++) mem[i] = $urandom;
        kick();
        run_body(LAT, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
